// File: rtl/wb_write_arbiter.sv
// Merges in-order WB writes and buffered mul/div results into one RF write port.
// Latency: write port is combinational (zero added cycles); md results wait in FIFO for an idle WB slot.
// Backpressure: md_ready drops when the FIFO is full; the pipeline WB is never stalled.
module wb_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          md_valid,
  input  logic [AW-1:0] md_addr,
  input  logic [DW-1:0] md_data,
  output logic          md_ready,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          pend_hit1,
  output logic          pend_hit2,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // FIFO storage: per-entry valid is reset, address/data are plain datapath.
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic wb_act;
  logic fifo_empty;
  logic head_vld;
  logic push;
  logic push_any;
  logic pop;

  assign wb_act     = wb_we && (wb_addr != '0);
  assign fifo_empty = (count_q == '0);
  assign head_vld   = !fifo_empty && vld_q[rd_ptr_q];
  assign md_ready   = (count_q < FULL);
  // An md result to r0 is acknowledged but never occupies an entry.
  assign push_any   = md_valid && md_ready;
  assign push       = push_any && (md_addr != '0);
  // Any idle WB slot retires the head, whether it is written or dropped as squashed.
  assign pop        = !wb_act && !fifo_empty;

  // Write-port mux: pipeline WB first, then a valid FIFO head, else quiet zeros.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (wb_act) begin
      rf_we    = 1'b1;
      rf_waddr = wb_addr;
      rf_wdata = wb_data;
    end else if (head_vld) begin
      rf_we    = 1'b1;
      rf_waddr = addr_q[rd_ptr_q];
      rf_wdata = data_q[rd_ptr_q];
    end
  end

  // Pending-write lookup for decode, from stored state only (a same-cycle push is not seen).
  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == rd_addr1)) pend_hit1 = 1'b1;
      if (vld_q[i] && (addr_q[i] == rd_addr2)) pend_hit2 = 1'b1;
    end
    if (rd_addr1 == '0) pend_hit1 = 1'b0;
    if (rd_addr2 == '0) pend_hit2 = 1'b0;
  end

  // Next-state: WAW squash of older entries, head retire, and tail insert.
  always_comb begin
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    if (wb_act) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == wb_addr) vld_d[i] = 1'b0;
      end
    end
    if (pop) begin
      // Clearing the retired slot keeps the pend lookup limited to live entries.
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push) begin
      // A result overwritten by the same-cycle WB is stored already dead.
      vld_d[wr_ptr_q] = !(wb_act && (md_addr == wb_addr));
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
  end

  // Control state with asynchronous reset; reset discards anything still queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload capture on push; contents are qualified by vld_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= md_addr;
      data_q[wr_ptr_q] <= md_data;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed table of per-cycle vectors plus a hand sequence for mid-cycle async reset.
// Inputs are driven after the falling edge; outputs are compared 1ns later, before the rising edge.
// Each table row is one clock cycle; expected values account for state from earlier rows.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  wb_write_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .md_valid (md_valid),
    .md_addr  (md_addr),
    .md_data  (md_data),
    .md_ready (md_ready),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .pend_hit1(pend_hit1),
    .pend_hit2(pend_hit2),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_rdy;
    logic        e_p1;
    logic        e_p2;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vec[64];
  int   nvec = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic e_rdy, input logic e_p1, input logic e_p2,
                     input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd);
    vec[nvec] = '{rst, we, wa, wd, mv, ma, md, r1, r2, e_rdy, e_p1, e_p2, e_we, e_wa, e_wd};
    nvec++;
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset    = v.rst;
    wb_we    = v.we;
    wb_addr  = v.wa;
    wb_data  = v.wd;
    md_valid = v.mv;
    md_addr  = v.ma;
    md_data  = v.md;
    rd_addr1 = v.r1;
    rd_addr2 = v.r2;
  endtask

  initial begin
    reset = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0; rd_addr1 = '0; rd_addr2 = '0;

    //   rst we wa  wd         mv ma  md          r1  r2   rdy p1 p2 we wa  wd
    // reset state
    add(1, 0, 0,  32'h0,      0, 0,  32'h0,      0,  0,   1,  0, 0, 0, 0,  32'h0);
    // WB passes straight through with an idle FIFO
    add(0, 1, 8,  32'h1234,   0, 0,  32'h0,      0,  0,   1,  0, 0, 1, 8,  32'h1234);
    // md result waits behind two busy WB cycles, drains in the first idle slot
    add(0, 1, 3,  32'h33,     1, 9,  32'hAAAA,   9,  0,   1,  0, 0, 1, 3,  32'h33);
    add(0, 1, 3,  32'h34,     0, 0,  32'h0,      9,  0,   1,  1, 0, 1, 3,  32'h34);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      9,  0,   1,  1, 0, 1, 9,  32'hAAAA);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      9,  0,   1,  0, 0, 0, 0,  32'h0);
    // fill to DEPTH, third result held until a pop, FIFO order retained
    add(0, 1, 4,  32'h44,     1, 10, 32'hA0,     0,  0,   1,  0, 0, 1, 4,  32'h44);
    add(0, 1, 4,  32'h45,     1, 11, 32'hB0,     10, 11,  1,  1, 0, 1, 4,  32'h45);
    add(0, 1, 6,  32'h66,     1, 12, 32'hC0,     10, 11,  0,  1, 1, 1, 6,  32'h66);
    add(0, 0, 0,  32'h0,      1, 12, 32'hC0,     10, 12,  0,  1, 0, 1, 10, 32'hA0);
    add(0, 0, 0,  32'h0,      1, 12, 32'hC0,     11, 10,  1,  1, 0, 1, 11, 32'hB0);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      12, 11,  1,  1, 0, 1, 12, 32'hC0);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      12, 0,   1,  0, 0, 0, 0,  32'h0);
    // WAW squash of a stored entry, then its slot is dropped without a write
    add(0, 0, 0,  32'h0,      1, 5,  32'h55,     0,  0,   1,  0, 0, 0, 0,  32'h0);
    add(0, 1, 5,  32'h77,     0, 0,  32'h0,      5,  0,   1,  1, 0, 1, 5,  32'h77);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      5,  0,   1,  0, 0, 0, 0,  32'h0);
    // squash of a same-cycle push; dead entry still holds space until popped
    add(0, 0, 0,  32'h0,      1, 7,  32'h70,     0,  0,   1,  0, 0, 0, 0,  32'h0);
    add(0, 1, 6,  32'h66,     1, 6,  32'h60,     7,  0,   1,  1, 0, 1, 6,  32'h66);
    add(0, 1, 2,  32'h23,     0, 0,  32'h0,      7,  6,   0,  1, 0, 1, 2,  32'h23);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      7,  6,   0,  1, 0, 1, 7,  32'h70);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      7,  6,   1,  0, 0, 0, 0,  32'h0);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      0,  0,   1,  0, 0, 0, 0,  32'h0);
    // md result to r0 is accepted and discarded
    add(0, 0, 0,  32'h0,      1, 0,  32'hDEAD,   0,  0,   1,  0, 0, 0, 0,  32'h0);
    add(0, 0, 0,  32'h0,      1, 0,  32'hBEEF,   0,  0,   1,  0, 0, 0, 0,  32'h0);
    add(0, 1, 6,  32'h61,     0, 0,  32'h0,      0,  0,   1,  0, 0, 1, 6,  32'h61);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      0,  0,   1,  0, 0, 0, 0,  32'h0);
    // WB to r0 is not a write and lets the FIFO drain
    add(0, 0, 0,  32'h0,      1, 15, 32'hF0,     0,  0,   1,  0, 0, 0, 0,  32'h0);
    add(0, 1, 0,  32'h99,     0, 0,  32'h0,      15, 0,   1,  1, 0, 1, 15, 32'hF0);
    add(0, 1, 0,  32'h99,     0, 0,  32'h0,      15, 0,   1,  0, 0, 0, 0,  32'h0);
    // reset with two entries queued; write port stays combinational during reset
    add(0, 1, 1,  32'h11,     1, 13, 32'hD0,     0,  0,   1,  0, 0, 1, 1,  32'h11);
    add(0, 1, 1,  32'h12,     1, 14, 32'hE0,     13, 0,   1,  1, 0, 1, 1,  32'h12);
    add(0, 1, 1,  32'h13,     0, 0,  32'h0,      13, 14,  0,  1, 1, 1, 1,  32'h13);
    add(1, 1, 1,  32'h14,     0, 0,  32'h0,      13, 14,  1,  0, 0, 1, 1,  32'h14);
    add(1, 0, 0,  32'h0,      0, 0,  32'h0,      13, 14,  1,  0, 0, 0, 0,  32'h0);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      13, 14,  1,  0, 0, 0, 0,  32'h0);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      13, 14,  1,  0, 0, 0, 0,  32'h0);

    for (int r = 0; r < nvec; r++) begin
      @(negedge clk);
      drive(vec[r]);
      #1;
      chk("md_ready",  r, {31'b0, md_ready},  {31'b0, vec[r].e_rdy});
      chk("pend_hit1", r, {31'b0, pend_hit1}, {31'b0, vec[r].e_p1});
      chk("pend_hit2", r, {31'b0, pend_hit2}, {31'b0, vec[r].e_p2});
      chk("rf_we",     r, {31'b0, rf_we},     {31'b0, vec[r].e_we});
      chk("rf_waddr",  r, {27'b0, rf_waddr},  {27'b0, vec[r].e_wa});
      chk("rf_wdata",  r, rf_wdata,           vec[r].e_wd);
    end

    // Hand sequence: asynchronous reset asserted mid-cycle with a full FIFO.
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h100;
    md_valid = 1'b1; md_addr = 5'd20; md_data = 32'h2020;
    @(negedge clk);
    md_addr = 5'd21; md_data = 32'h2121;
    @(negedge clk);
    md_valid = 1'b0; rd_addr1 = 5'd20; rd_addr2 = 5'd21;
    #1;
    chk("full_rdy",  100, {31'b0, md_ready},  32'd0);
    chk("full_p1",   100, {31'b0, pend_hit1}, 32'd1);
    chk("full_p2",   100, {31'b0, pend_hit2}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rdy",  101, {31'b0, md_ready},  32'd1);
    chk("arst_p1",   101, {31'b0, pend_hit1}, 32'd0);
    chk("arst_p2",   101, {31'b0, pend_hit2}, 32'd0);
    chk("arst_wb",   101, {27'b0, rf_waddr},  32'd1);
    wb_we = 1'b0;
    #1;
    chk("arst_we",   101, {31'b0, rf_we},     32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("post_we",  102 + k, {31'b0, rf_we},     32'd0);
      chk("post_rdy", 102 + k, {31'b0, md_ready},  32'd1);
      chk("post_p1",  102 + k, {31'b0, pend_hit1}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
